// File: rtl/neuron_pkg.sv
// Shared definitions for the spiking-neuron slice: FSM state encoding,
// default parameter values and a counter-sizing helper.
package neuron_pkg;

    typedef enum logic [1:0] {
        ST_INTEGRATE  = 2'b00,
        ST_FIRE       = 2'b01,
        ST_REFRACTORY = 2'b10
    } neuron_state_e;

    localparam int unsigned DEF_WIDTH          = 8;
    localparam int unsigned DEF_THRESHOLD      = 200;
    localparam int unsigned DEF_WEIGHT         = 64;
    localparam int unsigned DEF_LEAK_SHIFT     = 3;
    localparam int unsigned DEF_REFRACT_CYCLES = 4;

    // Bits needed to hold 0..n; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spike_sync.sv
// Two-flop synchronizer for an asynchronous spike line plus a history flop
// for rising-edge detection. Flops run every cycle, independent of any enable.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   async_in   : asynchronous spike input
//   rise_c     : one-cycle rising-edge pulse (decoded from flops, no input path)
module spike_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_c
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronizer chain and history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise_c = s2 & ~s3;

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron. Synchronized input spikes add WEIGHT to a
// saturating membrane that leaks by membrane >> LEAK_SHIFT each enabled cycle.
// Crossing THRESHOLD clears the membrane, emits a one-cycle spike_out and
// enters a refractory period of REFRACT_CYCLES enabled cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : cycle enable; low holds membrane/FSM/counter/spike_out
//   spike_in   : asynchronous input spike
//   spike_out  : registered fire pulse (high for the single FIRE cycle)
//   membrane   : registered membrane potential
//   refractory : registered, high while in FIRE or REFRACTORY
module lif_neuron
    import neuron_pkg::*;
#(
    parameter int unsigned WIDTH          = DEF_WIDTH,
    parameter int unsigned THRESHOLD      = DEF_THRESHOLD,
    parameter int unsigned WEIGHT         = DEF_WEIGHT,
    parameter int unsigned LEAK_SHIFT     = DEF_LEAK_SHIFT,
    parameter int unsigned REFRACT_CYCLES = DEF_REFRACT_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             spike_in,
    output logic             spike_out,
    output logic [WIDTH-1:0] membrane,
    output logic             refractory
);

    localparam int unsigned SUM_W = WIDTH + 1;
    localparam int unsigned CNT_W = cnt_width(REFRACT_CYCLES);

    localparam logic [WIDTH-1:0] MAX_V     = '1;
    localparam logic [WIDTH-1:0] THRESH_V  = WIDTH'(THRESHOLD);
    localparam logic [SUM_W-1:0] WEIGHT_V  = SUM_W'(WEIGHT);
    localparam logic [CNT_W-1:0] REFRACT_V = CNT_W'(REFRACT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             rise_c;
    logic [WIDTH-1:0] leak_c;
    logic [WIDTH-1:0] diff_c;
    logic [SUM_W-1:0] sum_c;
    logic [WIDTH-1:0] v_next_c;

    neuron_state_e    state;
    logic [CNT_W-1:0] cnt;

    spike_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (spike_in),
        .rise_c   (rise_c)
    );

    // Leak then integrate with one guard bit; clamp on overflow.
    always_comb begin
        leak_c   = membrane >> LEAK_SHIFT;
        diff_c   = membrane - leak_c;
        sum_c    = {1'b0, diff_c} + (rise_c ? WEIGHT_V : '0);
        v_next_c = sum_c[WIDTH] ? MAX_V : sum_c[WIDTH-1:0];
    end

    // Neuron FSM; every update is gated by ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INTEGRATE;
            membrane   <= '0;
            spike_out  <= 1'b0;
            refractory <= 1'b0;
            cnt        <= '0;
        end else if (ena) begin
            case (state)
                ST_INTEGRATE: begin
                    if (v_next_c >= THRESH_V) begin
                        membrane   <= '0;
                        state      <= ST_FIRE;
                        spike_out  <= 1'b1;
                        refractory <= 1'b1;
                    end else begin
                        membrane <= v_next_c;
                    end
                end
                ST_FIRE: begin
                    spike_out <= 1'b0;
                    membrane  <= '0;
                    if (REFRACT_CYCLES == 0) begin
                        state      <= ST_INTEGRATE;
                        refractory <= 1'b0;
                    end else begin
                        cnt   <= REFRACT_V;
                        state <= ST_REFRACTORY;
                    end
                end
                ST_REFRACTORY: begin
                    // Input rises are discarded here, including on the last cycle.
                    membrane <= '0;
                    if (cnt <= CNT_ONE) begin
                        cnt        <= '0;
                        state      <= ST_INTEGRATE;
                        refractory <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state      <= ST_INTEGRATE;
                    membrane   <= '0;
                    spike_out  <= 1'b0;
                    refractory <= 1'b0;
                    cnt        <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_neuron.sv
// Self-checking bench for lif_neuron: a default-parameter instance (a) and a
// WEIGHT=255/THRESHOLD=255/REFRACT_CYCLES=0 instance (b), directed scenarios
// plus randomized traffic against an arithmetic reference model.
module tb_lif_neuron;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena_a = 1'b0;
    logic       spike_a = 1'b0;
    logic       ena_b = 1'b0;
    logic       spike_b = 1'b0;
    logic       spk_out_a, ref_a, spk_out_b, ref_b;
    logic [7:0] mem_a, mem_b;

    int total = 0;
    int bad   = 0;

    // Reference model state, index 0 = instance a, 1 = instance b.
    int m_mem [2];
    int m_ref [2];
    bit m_fire[2];
    bit hist  [2][3];   // hist[i][0] = spike_in seen at previous edge, [1] two edges ago, ...
    int p_w   [2] = '{64, 255};
    int p_th  [2] = '{200, 255};
    int p_rc  [2] = '{4, 0};

    always #5 clk = ~clk;

    lif_neuron dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena_a),
        .spike_in   (spike_a),
        .spike_out  (spk_out_a),
        .membrane   (mem_a),
        .refractory (ref_a)
    );

    lif_neuron #(
        .WEIGHT         (255),
        .THRESHOLD      (255),
        .REFRACT_CYCLES (0)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena_b),
        .spike_in   (spike_b),
        .spike_out  (spk_out_b),
        .membrane   (mem_b),
        .refractory (ref_b)
    );

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_mem[i]  = 0;
            m_ref[i]  = 0;
            m_fire[i] = 1'b0;
            for (int j = 0; j < 3; j++) hist[i][j] = 1'b0;
        end
    endtask

    // One clock edge of the neuron described arithmetically.
    task automatic model_step(input int i, input bit en, input bit sin);
        bit rise;
        int nv;
        rise = hist[i][1] && !hist[i][2];
        if (en) begin
            if (m_fire[i]) begin
                m_fire[i] = 1'b0;
                m_ref[i]  = p_rc[i];
            end else if (m_ref[i] > 0) begin
                m_ref[i] = m_ref[i] - 1;
            end else begin
                nv = m_mem[i] - (m_mem[i] / 8) + (rise ? p_w[i] : 0);
                if (nv > 255) nv = 255;
                if (nv >= p_th[i]) begin
                    m_mem[i]  = 0;
                    m_fire[i] = 1'b1;
                end else begin
                    m_mem[i] = nv;
                end
            end
        end
        hist[i][2] = hist[i][1];
        hist[i][1] = hist[i][0];
        hist[i][0] = sin;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, ena_a, spike_a);
        model_step(1, ena_b, spike_b);
        #1;
    endtask

    task automatic do_reset();
        spike_a = 1'b0;
        spike_b = 1'b0;
        ena_a   = 1'b0;
        ena_b   = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (mem_a !== 8'd0) begin bad++; $display("FAIL reset_mem_a got=%0d want=0", mem_a); end
        total++; if (spk_out_a !== 1'b0) begin bad++; $display("FAIL reset_spk_a got=%b want=0", spk_out_a); end
        total++; if (ref_a !== 1'b0) begin bad++; $display("FAIL reset_ref_a got=%b want=0", ref_a); end
        total++; if (mem_b !== 8'd0) begin bad++; $display("FAIL reset_mem_b got=%0d want=0", mem_b); end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        ena_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (spk_out_a !== 1'b0 || mem_a !== 8'd0 || ref_a !== 1'b0) begin
                bad++; $display("FAIL idle_after_reset cyc=%0d got spk=%b mem=%0d ref=%b want 0/0/0", i, spk_out_a, mem_a, ref_a);
            end
        end
    endtask

    task automatic test_single_spike();
        int e[6] = '{0, 0, 64, 56, 49, 43};
        do_reset();
        ena_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            spike_a = (i == 0);
            tick();
            total++; if (mem_a !== 8'(e[i])) begin bad++; $display("FAIL single_mem cyc=%0d got=%0d want=%0d", i, mem_a, e[i]); end
            total++; if (spk_out_a !== 1'b0) begin bad++; $display("FAIL single_spk cyc=%0d got=%b want=0", i, spk_out_a); end
        end
    endtask

    task automatic test_train_fire_refract();
        int em[17] = '{0, 0, 64, 56, 113, 99, 151, 133, 181, 159, 0, 0, 0, 0, 0, 0, 64};
        do_reset();
        ena_a = 1'b1;
        for (int i = 0; i < 17; i++) begin
            spike_a = (i % 2 == 0);
            tick();
            total++; if (mem_a !== 8'(em[i])) begin bad++; $display("FAIL train_mem cyc=%0d got=%0d want=%0d", i, mem_a, em[i]); end
            total++; if (spk_out_a !== (i == 10)) begin bad++; $display("FAIL train_spk cyc=%0d got=%b want=%b", i, spk_out_a, (i == 10)); end
            total++; if (ref_a !== (i >= 10 && i <= 14)) begin bad++; $display("FAIL train_ref cyc=%0d got=%b want=%b", i, ref_a, (i >= 10 && i <= 14)); end
        end
    endtask

    task automatic test_ena_hold();
        do_reset();
        ena_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            spike_a = (i == 0 || i == 2);
            tick();
        end
        total++; if (mem_a !== 8'd113) begin bad++; $display("FAIL hold_setup got=%0d want=113", mem_a); end
        ena_a = 1'b0;
        for (int h = 0; h < 10; h++) begin
            spike_a = (h == 1 || h == 2 || h == 5);
            tick();
            total++; if (mem_a !== 8'd113 || spk_out_a !== 1'b0) begin
                bad++; $display("FAIL hold_mem cyc=%0d got mem=%0d spk=%b want 113/0", h, mem_a, spk_out_a);
            end
        end
        spike_a = 1'b0;
        ena_a   = 1'b1;
        tick();
        total++; if (mem_a !== 8'd99) begin bad++; $display("FAIL hold_resume got=%0d want=99", mem_a); end
    endtask

    task automatic test_reset_mid_refract();
        bit fired = 1'b0;
        do_reset();
        ena_a = 1'b1;
        for (int i = 0; i < 30 && !fired; i++) begin
            spike_a = (i % 2 == 0);
            tick();
            fired = spk_out_a;
        end
        total++; if (!fired) begin bad++; $display("FAIL midrst_fire got=no_fire want=fire within 30 cycles"); end
        spike_a = 1'b0;
        tick();
        tick();
        total++; if (ref_a !== 1'b1) begin bad++; $display("FAIL midrst_in_refract got=%b want=1", ref_a); end
        #3 rst_n = 1'b0;
        #1;
        total++; if (ref_a !== 1'b0 || spk_out_a !== 1'b0 || mem_a !== 8'd0) begin
            bad++; $display("FAIL midrst_immediate got ref=%b spk=%b mem=%0d want 0/0/0", ref_a, spk_out_a, mem_a);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        for (int i = 0; i < 8; i++) begin
            tick();
            total++; if (ref_a !== 1'b0 || spk_out_a !== 1'b0 || mem_a !== 8'd0) begin
                bad++; $display("FAIL midrst_after cyc=%0d got ref=%b spk=%b mem=%0d want 0/0/0", i, ref_a, spk_out_a, mem_a);
            end
        end
    endtask

    task automatic test_saturation_norefract();
        do_reset();
        ena_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            spike_b = (i == 0 || i == 2);
            tick();
            total++; if (spk_out_b !== (i == 2 || i == 4)) begin bad++; $display("FAIL sat_spk cyc=%0d got=%b want=%b", i, spk_out_b, (i == 2 || i == 4)); end
            total++; if (ref_b !== (i == 2 || i == 4)) begin bad++; $display("FAIL sat_ref cyc=%0d got=%b want=%b", i, ref_b, (i == 2 || i == 4)); end
            total++; if (mem_b !== 8'd0) begin bad++; $display("FAIL sat_mem cyc=%0d got=%0d want=0", i, mem_b); end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_m;
        logic       exp_r;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            ena_a   = ($urandom_range(0, 3) != 0);
            spike_a = ($urandom_range(0, 2) == 0);
            ena_b   = ($urandom_range(0, 3) != 0);
            spike_b = ($urandom_range(0, 4) == 0);
            tick();
            exp_m = 8'(m_mem[0]);
            exp_r = m_fire[0] || (m_ref[0] > 0);
            total++; if (mem_a !== exp_m) begin bad++; $display("FAIL rand_mem_a n=%0d got=%0d want=%0d", n, mem_a, exp_m); end
            total++; if (spk_out_a !== m_fire[0]) begin bad++; $display("FAIL rand_spk_a n=%0d got=%b want=%b", n, spk_out_a, m_fire[0]); end
            total++; if (ref_a !== exp_r) begin bad++; $display("FAIL rand_ref_a n=%0d got=%b want=%b", n, ref_a, exp_r); end
            exp_m = 8'(m_mem[1]);
            exp_r = m_fire[1] || (m_ref[1] > 0);
            total++; if (mem_b !== exp_m) begin bad++; $display("FAIL rand_mem_b n=%0d got=%0d want=%0d", n, mem_b, exp_m); end
            total++; if (spk_out_b !== m_fire[1]) begin bad++; $display("FAIL rand_spk_b n=%0d got=%b want=%b", n, spk_out_b, m_fire[1]); end
            total++; if (ref_b !== exp_r) begin bad++; $display("FAIL rand_ref_b n=%0d got=%b want=%b", n, ref_b, exp_r); end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_spike();
        test_train_fire_refract();
        test_ena_hold();
        test_reset_mid_refract();
        test_saturation_norefract();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
